// File: rtl/elevator_call_scheduler_if.sv
// Call/request bundle between the button panel, the scheduler and the car controller.
// The slave modport is the scheduler's side; the master modport is the panel/controller side.
interface elevator_call_scheduler_if #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int LEVEL_WIDTH   = 3
);
    logic                     buttons_block;
    logic [BUTTONS_WIDTH-1:0] btn_in;
    logic [BUTTONS_WIDTH-2:0] btn_up_out;
    logic [BUTTONS_WIDTH-2:0] btn_down_out;
    logic [LEVEL_WIDTH-1:0]   level;
    logic                     level_valid;
    logic                     served;

    logic [BUTTONS_WIDTH-1:0] pending_in;
    logic [BUTTONS_WIDTH-2:0] pending_up;
    logic [BUTTONS_WIDTH-2:0] pending_down;
    logic                     direction;
    logic                     req_valid;
    logic [LEVEL_WIDTH-1:0]   req_level;
    logic                     stop_here;
    logic                     idle;

    modport master (
        output buttons_block, btn_in, btn_up_out, btn_down_out, level, level_valid, served,
        input  pending_in, pending_up, pending_down, direction, req_valid, req_level, stop_here, idle
    );

    modport slave (
        input  buttons_block, btn_in, btn_up_out, btn_down_out, level, level_valid, served,
        output pending_in, pending_up, pending_down, direction, req_valid, req_level, stop_here, idle
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Directional-collective elevator call scheduler: latches calls, tracks IDLE/UP/DOWN travel.
// Latency: button press visible on pending_* one edge later; targets/stop are combinational from state and level.
// Backpressure: none; buttons_block masks new presses, served pulses clear calls at the aligned floor.
module elevator_call_scheduler #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int LEVEL_WIDTH   = 3
) (
    input  logic                        clock,
    input  logic                        a_reset,
    elevator_call_scheduler_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t                   state;
    logic                     dir_q;
    logic [BUTTONS_WIDTH-1:0] pin_q;
    logic [BUTTONS_WIDTH-2:0] pup_q;
    logic [BUTTONS_WIDTH-2:0] pdn_q;

    // Hall calls widened to one bit per floor; missing top-up / bottom-down read 0.
    logic [BUTTONS_WIDTH-1:0] up_full;
    logic [BUTTONS_WIDTH-1:0] dn_full;
    logic [BUTTONS_WIDTH-1:0] any_call;
    assign up_full  = {1'b0, pup_q};
    assign dn_full  = {pdn_q, 1'b0};
    assign any_call = pin_q | up_full | dn_full;

    int   lvl;
    logic in_range;
    logic act;
    assign lvl      = int'(bus.level);
    assign in_range = (lvl < BUTTONS_WIDTH);
    assign act      = bus.level_valid & in_range;

    logic                     above, below;
    logic                     here_in, here_up, here_dn;
    logic [LEVEL_WIDTH-1:0]   lo_above, hi_below;
    logic [BUTTONS_WIDTH-1:0] level_hot;

    always_comb begin
        above     = 1'b0;
        below     = 1'b0;
        here_in   = 1'b0;
        here_up   = 1'b0;
        here_dn   = 1'b0;
        lo_above  = '0;
        hi_below  = '0;
        level_hot = '0;
        // Descending scan so the last hit is the nearest call above.
        for (int i = BUTTONS_WIDTH - 1; i >= 0; i--) begin
            if (in_range && i > lvl && any_call[i]) begin
                above    = 1'b1;
                lo_above = LEVEL_WIDTH'(i);
            end
        end
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (in_range && i < lvl && any_call[i]) begin
                below    = 1'b1;
                hi_below = LEVEL_WIDTH'(i);
            end
            if (i == lvl) begin
                here_in      = pin_q[i];
                here_up      = up_full[i];
                here_dn      = dn_full[i];
                level_hot[i] = 1'b1;
            end
        end
    end

    logic h_up, h_dn;
    assign h_up = here_in | here_up;
    assign h_dn = here_in | here_dn;

    logic stop_c;
    always_comb begin
        stop_c = 1'b0;
        if (act) begin
            case (state)
                UP:      stop_c = h_up | (!above & here_dn);
                DOWN:    stop_c = h_dn | (!below & here_up);
                IDLE:    stop_c = h_up | h_dn;
                default: stop_c = 1'b0;
            endcase
        end
    end

    // A hall call in the opposite direction is only cleared when the car turns around here.
    logic                     up_clr_en, dn_clr_en;
    logic [BUTTONS_WIDTH-1:0] clr_in, clr_up, clr_dn;
    assign up_clr_en = dir_q | (state == IDLE) | ((state == DOWN) & !below);
    assign dn_clr_en = !dir_q | (state == IDLE) | ((state == UP) & !above);
    assign clr_in    = (bus.served && act) ? level_hot : '0;
    assign clr_up    = clr_in & {BUTTONS_WIDTH{up_clr_en}};
    assign clr_dn    = clr_in & {BUTTONS_WIDTH{dn_clr_en}};

    always_ff @(posedge clock or posedge a_reset) begin
        if (a_reset) begin
            state <= IDLE;
            dir_q <= 1'b1;
            pin_q <= '0;
            pup_q <= '0;
            pdn_q <= '0;
        end else begin
            pin_q <= (pin_q & ~clr_in) | (bus.btn_in & {BUTTONS_WIDTH{~bus.buttons_block}});
            pup_q <= (pup_q & ~clr_up[BUTTONS_WIDTH-2:0])
                   | (bus.btn_up_out & {(BUTTONS_WIDTH-1){~bus.buttons_block}});
            pdn_q <= (pdn_q & ~clr_dn[BUTTONS_WIDTH-1:1])
                   | (bus.btn_down_out & {(BUTTONS_WIDTH-1){~bus.buttons_block}});
            if (act) begin
                case (state)
                    IDLE: begin
                        if (above) begin
                            state <= UP;
                            dir_q <= 1'b1;
                        end else if (below) begin
                            state <= DOWN;
                            dir_q <= 1'b0;
                        end
                    end
                    UP: begin
                        if (!above) begin
                            if (h_dn | below) begin
                                state <= DOWN;
                                dir_q <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DOWN: begin
                        if (!below) begin
                            if (h_up | above) begin
                                state <= UP;
                                dir_q <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic                   req_valid_c;
    logic [LEVEL_WIDTH-1:0] target;
    assign req_valid_c = above | below | stop_c;
    always_comb begin
        case (state)
            UP:      target = above ? lo_above : bus.level;
            DOWN:    target = below ? hi_below : bus.level;
            default: target = bus.level;
        endcase
    end

    assign bus.pending_in   = pin_q;
    assign bus.pending_up   = pup_q;
    assign bus.pending_down = pdn_q;
    assign bus.direction    = dir_q;
    assign bus.stop_here    = stop_c;
    assign bus.req_valid    = req_valid_c;
    assign bus.req_level    = req_valid_c ? target : '0;
    assign bus.idle         = (state == IDLE) && (any_call == '0);
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Directional-collective call scheduler sitting between the button inputs (car panel, hall up, hall down) and the elevator car controller.
- Latches every call and keeps a travel state (IDLE / UP / DOWN).
- Each cycle it tells the car controller which floor to head for next and whether to stop at the current floor.
- Clears the calls it has served, using the controller's `served` pulse.

Parameters:
- BUTTONS_WIDTH, 8, number of floors (floor 0 .. BUTTONS_WIDTH-1).
- LEVEL_WIDTH, 3, width of floor-number buses; must satisfy 2**LEVEL_WIDTH >= BUTTONS_WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- a_reset  in  1  asynchronous, active-high reset.
- buttons_block  in  1  while high, new presses on all button inputs are ignored.
- btn_in  in  BUTTONS_WIDTH  car-panel call per floor, level-sensitive.
- btn_up_out  in  BUTTONS_WIDTH-1  hall up call, floors 0..W-2.
- btn_down_out  in  BUTTONS_WIDTH-1  hall down call, bit i-1 = floor i, floors 1..W-1.
- level  in  LEVEL_WIDTH  current car floor.
- level_valid  in  1  car is stationary and aligned at `level`.
- served  in  1  one-cycle pulse: doors opened at `level`.
- pending_in  out  BUTTONS_WIDTH  latched car calls (lamp drive).
- pending_up  out  BUTTONS_WIDTH-1  latched hall up calls.
- pending_down  out  BUTTONS_WIDTH-1  latched hall down calls.
- direction  out  1  1 = up, 0 = down; last travel direction.
- req_valid  out  1  a target exists.
- req_level  out  LEVEL_WIDTH  next target floor.
- stop_here  out  1  car must stop or open at `level`.
- idle  out  1  state IDLE and no call pending.

Behaviour:
- Reset (async, a_reset=1):
  - all pending bits 0, state IDLE, direction 1, req_valid 0, req_level 0, stop_here 0, idle 1.
  - Reset mid-travel discards all calls immediately.
- Call latching, each edge:
  - pending_x <= (pending_x & ~clr_x) | (btn_x & {~buttons_block}).
  - A set in the same cycle as a clear wins; the bit stays 1.
  - Latency: a press sampled at edge n is visible on pending_* after edge n.
- Derived terms (combinational from registers and `level`):
  - above = any pending bit at a floor > level.
  - below = any pending bit at a floor < level.
  - h_up = pending_in[level] | pending_up[level].
  - h_dn = pending_in[level] | pending_down[level].
  - Nonexistent bits (up at top floor, down at floor 0) read 0.
- Out-of-range `level` (>= BUTTONS_WIDTH): above/below/h_* are 0, stop_here 0, served ignored, state held.
- level_valid=0: state held, stop_here 0, served ignored.
- State transitions, evaluated only when level_valid=1:
  - IDLE -> UP if above.
  - IDLE -> DOWN if !above && below.
  - Otherwise IDLE. Up has priority when calls exist both above and below.
  - UP stays UP while above. If !above: -> DOWN if h_dn | below, else -> IDLE.
  - DOWN stays DOWN while below. If !below: -> UP if h_up | above, else -> IDLE.
  - direction is updated on entry to UP (1) or DOWN (0) and held in IDLE.
- stop_here (combinational, level_valid=1 and level in range):
  - UP: h_up, or (!above && pending_down[level]).
  - DOWN: h_dn, or (!below && pending_up[level]).
  - IDLE: h_up | h_dn.
- served (level_valid=1): clears bits at `level` on that edge.
  - Always clears pending_in[level].
  - Clears pending_up[level] if direction=1 or state=IDLE.
  - Clears pending_down[level] if direction=0 or state=IDLE.
  - In UP with !above, also clears pending_down[level] (reversal at a floor); symmetric for DOWN.
- req_level:
  - UP: lowest pending floor > level.
  - DOWN: highest pending floor < level.
  - IDLE: level.
- req_valid = above | below | stop_here.
- No combinational path from btn_* to any output; btn_* to outputs is always at least 1 cycle.

Test Plan:
1. Reset, then level=0, level_valid=1, pulse btn_in[6] one cycle -> pending_in=0x40 next cycle; then state UP, direction=1, req_level=6, req_valid=1. At level=6: stop_here=1; served -> pending_in=0, state IDLE, idle=1.
2. Car at level=2 in UP, pending_up[4], pending_down[4], pending_in[6] -> at level=4 stop_here=1; served clears only up[4], down[4] stays 1. At 6 after served -> DOWN, req_level=4.
3. IDLE at level=3, btn_up_out[5] and btn_in[1] pressed in the same cycle -> UP chosen, req_level=5. After serving 5 -> DOWN, req_level=1.
4. buttons_block=1 while pulsing btn_in[7] and btn_down_out[2] (floor 3) -> pending_* stay 0, idle stays 1. Deassert and press again -> latched.
5. Press btn_in[4] in the same cycle as served at level=4 -> pending_in[4] remains 1, stop_here stays 1.
6. a_reset pulsed mid-travel (UP, three calls pending), asynchronously between edges -> all outputs at reset values immediately. level_valid=0 with served=1 -> no bit cleared.
